// File: rtl/iob_fp_pkg.sv
// Shared constants, state encoding and field helpers for the iob_fp accumulator family.
package iob_fp_pkg;

  localparam int DATA_W  = 32;
  localparam int EXP_W   = 8;
  localparam int ADD_LAT = 5;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;

  typedef enum logic [1:0] {
    ACCUM = ST_ACCUM,
    DRAIN = ST_DRAIN,
    OUT   = ST_OUT
  } acc_state_t;

  function automatic logic [EXP_W-1:0] exp_field(input logic [DATA_W-1:0] w);
    return w[DATA_W-2 -: EXP_W];
  endfunction

endpackage

// File: rtl/iob_fp_add.sv
// Five-stage pipelined floating-point adder for normal operands: swap, align, add, normalise, round/pack.
module iob_fp_add #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              done_o,
  output logic [DATA_W-1:0] res_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              exception_o
);

  localparam int MAN_W = DATA_W - EXP_W - 1;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int LZ_W  = $clog2(EXT_W + 1);
  localparam int XE_W  = EXP_W + 2;
  localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((1 << EXP_W) - 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [EXT_W-1:0] v);
    lzc = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++)
      if (v[i]) lzc = LZ_W'(EXT_W - 1 - i);
  endfunction

  logic [4:0] vld;

  // Stage 1: order operands by magnitude so the shifter only ever moves the smaller one.
  logic                 s1_sign, s1_sub;
  logic [EXP_W-1:0]     s1_exp, s1_diff;
  logic [SIG_W-1:0]     s1_mbig, s1_msml;
  logic [DATA_W-1:0]    big, sml;

  always_comb begin
    big = op_a_i;
    sml = op_b_i;
    if (op_b_i[DATA_W-2:0] > op_a_i[DATA_W-2:0]) begin
      big = op_b_i;
      sml = op_a_i;
    end
  end

  // Stage 2 combinational: align with guard/round/sticky, then add or subtract.
  logic [EXT_W-1:0]     ext_sml, shifted, mask, aligned, ext_big;
  logic [EXT_W:0]       sum_c;
  logic [EXT_W:0]       s2_sum;
  logic [EXP_W-1:0]     s2_exp;
  logic                 s2_sign;

  always_comb begin
    ext_sml = {s1_msml, 3'b000};
    ext_big = {s1_mbig, 3'b000};
    shifted = ext_sml >> s1_diff;
    mask    = ~({EXT_W{1'b1}} << s1_diff);
    if (int'(s1_diff) >= EXT_W) aligned = {{(EXT_W-1){1'b0}}, 1'b1};
    else                        aligned = shifted | {{(EXT_W-1){1'b0}}, |(ext_sml & mask)};
    if (s1_sub) sum_c = {1'b0, ext_big} - {1'b0, aligned};
    else        sum_c = {1'b0, ext_big} + {1'b0, aligned};
  end

  // Stage 3 combinational: normalise so the leading one sits at bit EXT_W-1.
  logic [LZ_W-1:0]        lz;
  logic [EXT_W-1:0]       norm_c;
  logic signed [XE_W-1:0] nexp_c, s3_exp;
  logic [EXT_W-1:0]       s3_norm;
  logic                   s3_zero, s3_sign;

  always_comb begin
    lz     = lzc(s2_sum[EXT_W-1:0]);
    norm_c = s2_sum[EXT_W-1:0] << lz;
    nexp_c = $signed({2'b00, s2_exp}) - $signed({{(XE_W-LZ_W){1'b0}}, lz});
    if (s2_sum[EXT_W]) begin
      norm_c = s2_sum[EXT_W:1] | {{(EXT_W-1){1'b0}}, s2_sum[0]};
      nexp_c = $signed({2'b00, s2_exp}) + XE_W'(1);
    end
  end

  // Stage 4 combinational: round to nearest even, renormalising on mantissa carry-out.
  logic [SIG_W:0]         rnd;
  logic                   up;
  logic [MAN_W-1:0]       s4_man;
  logic signed [XE_W-1:0] s4_exp;
  logic                   s4_zero, s4_sign;

  always_comb begin
    up  = s3_norm[2] & (s3_norm[1] | s3_norm[0] | s3_norm[3]);
    rnd = {1'b0, s3_norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, up};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) vld <= '0;
    else       vld <= {vld[3:0], start_i};
  end

  always_ff @(posedge clk_i) begin
    s1_sign <= big[DATA_W-1];
    s1_sub  <= big[DATA_W-1] ^ sml[DATA_W-1];
    s1_exp  <= big[DATA_W-2 -: EXP_W];
    s1_diff <= big[DATA_W-2 -: EXP_W] - sml[DATA_W-2 -: EXP_W];
    s1_mbig <= {1'b1, big[MAN_W-1:0]};
    s1_msml <= {1'b1, sml[MAN_W-1:0]};

    s2_sum  <= sum_c;
    s2_exp  <= s1_exp;
    s2_sign <= s1_sign;

    s3_norm <= norm_c;
    s3_exp  <= nexp_c;
    s3_zero <= (s2_sum == '0);
    s3_sign <= s2_sign;

    s4_man  <= rnd[SIG_W] ? rnd[SIG_W-1:1] : rnd[MAN_W-1:0];
    s4_exp  <= rnd[SIG_W] ? s3_exp + XE_W'(1) : s3_exp;
    s4_zero <= s3_zero;
    s4_sign <= s3_sign;
  end

  // Stage 5: pack; results below the normal range flush to +0, above it saturate to infinity.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o      <= 1'b0;
      res_o       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      exception_o <= 1'b0;
    end else begin
      done_o      <= vld[3];
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      exception_o <= 1'b0;
      if (s4_zero) begin
        res_o <= '0;
      end else if (s4_exp <= 0) begin
        res_o       <= '0;
        underflow_o <= vld[3];
      end else if (s4_exp >= EXP_MAX) begin
        res_o       <= {s4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        overflow_o  <= vld[3];
      end else begin
        res_o <= {s4_sign, s4_exp[EXP_W-1:0], s4_man};
      end
    end
  end

endmodule

// File: rtl/iob_fp_acc.sv
// Streaming FP accumulator: pairs incoming operands and returning adder results so one add can
// issue per cycle, then drains all partial sums into a single total.
module iob_fp_acc
  import iob_fp_pkg::*;
#(
  parameter int DATA_W  = iob_fp_pkg::DATA_W,
  parameter int EXP_W   = iob_fp_pkg::EXP_W,
  parameter int ADD_LAT = iob_fp_pkg::ADD_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o
);

  localparam int FL_W = $clog2(ADD_LAT + 1);

  // Both streams: a beat transfers on the rising edge where valid & ready are high; the producer
  // holds valid and data stable until then, ready never depends on valid.

  acc_state_t        state;
  logic [FL_W-1:0]   in_flight;
  logic              hold_v;
  logic [DATA_W-1:0] hold;

  logic              add_done;
  logic [DATA_W-1:0] add_res;
  logic              ret_v, in_acc, inp;
  logic              start, hold_load, hold_clr;
  logic [DATA_W-1:0] op_a, op_b, hold_d;

  // Zero-exponent words are dropped: the adder only handles normal operands.
  assign ret_v      = add_done & (exp_field(add_res) != '0);
  assign in_ready_o = (state == ACCUM) & !(ret_v & hold_v);
  assign in_acc     = in_valid_i & in_ready_o;
  assign inp        = in_acc & (exp_field(in_data_i) != '0);
  assign busy_o     = (state != ACCUM) | (in_flight != '0);

  always_comb begin
    start     = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    op_a      = add_res;
    op_b      = hold;
    hold_d    = add_res;
    if (state != OUT) begin
      if (ret_v & hold_v) begin
        start    = 1'b1;
        hold_clr = 1'b1;
      end else if (ret_v & inp) begin
        start = 1'b1;
        op_b  = in_data_i;
      end else if (ret_v) begin
        hold_load = 1'b1;
      end else if (inp & hold_v) begin
        start    = 1'b1;
        op_a     = in_data_i;
        hold_clr = 1'b1;
      end else if (inp) begin
        hold_load = 1'b1;
        hold_d    = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ACCUM;
      in_flight   <= '0;
      hold_v      <= 1'b0;
      hold        <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else begin
      if (hold_load) begin
        hold   <= hold_d;
        hold_v <= 1'b1;
      end else if (hold_clr) begin
        hold_v <= 1'b0;
      end

      if (start && !add_done)      in_flight <= in_flight + 1'b1;
      else if (!start && add_done) in_flight <= in_flight - 1'b1;

      case (state)
        ACCUM: if (in_acc && in_last_i) state <= DRAIN;
        DRAIN: begin
          if (in_flight == '0 && !add_done) begin
            state       <= OUT;
            out_valid_o <= 1'b1;
            out_data_o  <= hold_v ? hold : '0;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            state       <= ACCUM;
            out_valid_o <= 1'b0;
            hold_v      <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  iob_fp_add #(
    .DATA_W (DATA_W),
    .EXP_W  (EXP_W)
  ) u_add (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .done_o      (add_done),
    .res_o       (add_res),
    .overflow_o  (),
    .underflow_o (),
    .exception_o ()
  );

endmodule

// File: tb/tb_iob_fp_acc.sv
// Directed bench for iob_fp_acc: hand-computed totals, latency, backpressure and reset abort.
module tb_iob_fp_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int max_flight = 0;

  always #5 clk = ~clk;

  iob_fp_acc dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  always @(negedge clk)
    if (int'(dut.in_flight) > max_flight) max_flight = int'(dut.in_flight);

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_op(input logic [31:0] d, input logic l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL send_op: in_ready stuck low, data=%h", d);
    end
    @(negedge clk);
  endtask

  task automatic get_result(input string name, input logic [31:0] exp);
    int guard;
    guard     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (!out_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL %s: no out_valid within bound", name);
    end else if (out_data !== exp) begin
      n_err++;
      $display("FAIL %s: out_data=%h expected=%h", name, out_data, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec += 4;
    if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_data !== 32'h0)  begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_three();
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b0);
    send_op(32'h40400000, 1'b1);
    get_result("three_ops", 32'h40C00000);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL three_back_to_accum: in_ready=%b expected 1", in_ready); end
  endtask

  task automatic test_continuous();
    max_flight = 0;
    for (int i = 0; i < 16; i++) send_op(32'h3F800000, i == 15);
    get_result("continuous_16", 32'h41800000);
    n_vec++;
    if (max_flight > 5) begin n_err++; $display("FAIL continuous_in_flight: max=%0d limit=5", max_flight); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send_op(32'hC0490FDB, 1'b1);
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_cycle1: out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    n_vec += 2;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_cycle2: out_valid=%b expected 1", out_valid); end
    if (out_data !== 32'hC0490FDB) begin n_err++; $display("FAIL single_data: got %h expected c0490fdb", out_data); end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_release: out_valid=%b expected 0", out_valid); end
    send_op(32'h00000000, 1'b1);
    get_result("zero_only", 32'h00000000);
  endtask

  task automatic test_backpressure();
    int guard;
    out_ready = 1'b0;
    send_op(32'h3F800000, 1'b0);
    send_op(32'h3F800000, 1'b1);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      n_vec += 3;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 32'h40000000) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected 40000000", i, out_data); end
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1)  begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) send_op(32'h3F800000, i == 5);
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec += 3;
    if (in_ready !== 1'b1)  begin n_err++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0)      begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
    send_op(32'h40000000, 1'b0);
    send_op(32'h40000000, 1'b1);
    get_result("after_reset_2p2", 32'h40800000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_three();
    test_continuous();
    test_single();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
